// File: rtl/regread_stage.sv
// Register-read stage: decodes the fetched instruction, reads operands and stalls on in-flight writers.
// Optional WB_BYPASS_EN forwards the write port into same-cycle reads; otherwise a third tracker entry stalls.
module regread_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_pc,
    input  logic [15:0] in_ins,
    input  logic        wb_en,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        flush,
    output logic        fr_valid,
    output logic [15:0] fr_pc,
    output logic [15:0] fr_ins,
    output logic [15:0] fr_operand_1,
    output logic [15:0] fr_operand_2
);
    localparam int unsigned XLEN = 16;
    localparam int unsigned RIDX = 4;
    localparam int unsigned NREG = 16;
    localparam logic [XLEN-1:0] NOP_INS = 16'hF000;

    logic [XLEN-1:0] regs [NREG];

    logic [3:0]      opcode, ra, rb, rd;
    logic [RIDX-1:0] src1, src2;
    logic            use1, use2, writes;
    logic [XLEN-1:0] op1, op2;
    logic            match1, match2, hazard, accept;

    logic            d1_v, d2_v;
    logic [RIDX-1:0] d1, d2;
`ifndef WB_BYPASS_EN
    logic            d3_v;
    logic [RIDX-1:0] d3;
`endif

    // Decode: which fields are sources, and whether rd is written
    always_comb begin
        opcode = in_ins[15:12];
        ra     = in_ins[11:8];
        rb     = in_ins[7:4];
        rd     = in_ins[3:0];
        src1   = '0;
        src2   = '0;
        use1   = 1'b0;
        use2   = 1'b0;
        writes = 1'b0;
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'hE: begin
                src1 = ra; use1 = 1'b1;
                src2 = rb; use2 = 1'b1;
                writes = 1'b1;
            end
            4'h4, 4'hC, 4'hD: begin
                // rb doubles as the memory subcode; 1 selects store
                if (rb == 4'h1) begin
                    src1 = rd; use1 = 1'b1;
                    src2 = ra; use2 = 1'b1;
                end else begin
                    src1 = ra; use1 = 1'b1;
                    writes = 1'b1;
                end
            end
            4'h7: begin
                src1 = ra; use1 = 1'b1;
                writes = 1'b1;
            end
            4'h6: begin
                src1 = rd; use1 = 1'b1;
                src2 = ra; use2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand read; unused or R0 sources read as zero
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (use1 && src1 != '0) op1 = regs[src1];
        if (use2 && src2 != '0) op2 = regs[src2];
`ifdef WB_BYPASS_EN
        if (use1 && src1 != '0 && wb_en && wb_reg == src1) op1 = wb_data;
        if (use2 && src2 != '0 && wb_en && wb_reg == src2) op2 = wb_data;
`endif
    end

    // Hazard against in-flight writers
    always_comb begin
        match1 = use1 && src1 != '0 && ((d1_v && d1 == src1) || (d2_v && d2 == src1));
        match2 = use2 && src2 != '0 && ((d1_v && d1 == src2) || (d2_v && d2 == src2));
`ifndef WB_BYPASS_EN
        match1 = match1 || (use1 && src1 != '0 && d3_v && d3 == src1);
        match2 = match2 || (use2 && src2 != '0 && d3_v && d3 == src2);
`endif
        hazard   = in_valid && (match1 || match2);
        in_ready = rst || flush || !hazard;
        accept   = in_valid && !flush && !hazard;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[RIDX'(i)] <= '0;
        end else if (wb_en && wb_reg != '0) begin
            regs[wb_reg] <= wb_data;
        end
    end

    // Issue slot and destination tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fr_valid     <= 1'b0;
            fr_pc        <= '0;
            fr_ins       <= NOP_INS;
            fr_operand_1 <= '0;
            fr_operand_2 <= '0;
            d1_v         <= 1'b0;
            d1           <= '0;
            d2_v         <= 1'b0;
            d2           <= '0;
`ifndef WB_BYPASS_EN
            d3_v         <= 1'b0;
            d3           <= '0;
`endif
        end else begin
            if (accept) begin
                fr_valid     <= 1'b1;
                fr_pc        <= in_pc;
                fr_ins       <= in_ins;
                fr_operand_1 <= op1;
                fr_operand_2 <= op2;
                d1_v         <= writes;
                d1           <= rd;
            end else begin
                fr_valid     <= 1'b0;
                fr_pc        <= '0;
                fr_ins       <= NOP_INS;
                fr_operand_1 <= '0;
                fr_operand_2 <= '0;
                d1_v         <= 1'b0;
                d1           <= '0;
            end
            d2_v <= d1_v && !flush;
            d2   <= d1;
`ifndef WB_BYPASS_EN
            d3_v <= d2_v && !flush;
            d3   <= d2;
`endif
        end
    end
endmodule

// File: tb/tb_regread_stage.sv
// Directed self-checking bench for regread_stage; follows WB_BYPASS_EN when defined.
module tb_regread_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_ins;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        flush;
    logic        fr_valid;
    logic [15:0] fr_pc;
    logic [15:0] fr_ins;
    logic [15:0] fr_operand_1;
    logic [15:0] fr_operand_2;

    int checks = 0;
    int errors = 0;

`ifdef WB_BYPASS_EN
    localparam int EXP_STALLS = 2;
`else
    localparam int EXP_STALLS = 3;
`endif

    regread_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ins(in_ins),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush),
        .fr_valid(fr_valid), .fr_pc(fr_pc), .fr_ins(fr_ins),
        .fr_operand_1(fr_operand_1), .fr_operand_2(fr_operand_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_fr(input string tag, input logic v, input logic [15:0] pc,
                            input logic [15:0] ins, input logic [15:0] o1, input logic [15:0] o2);
        check({tag, ".valid"}, 32'(fr_valid), 32'(v));
        check({tag, ".pc"}, 32'(fr_pc), 32'(pc));
        check({tag, ".ins"}, 32'(fr_ins), 32'(ins));
        check({tag, ".op1"}, 32'(fr_operand_1), 32'(o1));
        check({tag, ".op2"}, 32'(fr_operand_2), 32'(o2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [15:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic offer(input logic [15:0] pc, input logic [15:0] ins);
        in_valid = 1'b1; in_pc = pc; in_ins = ins;
        #1;
    endtask

    int stalls;
    logic done;

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_pc = 16'h0055; in_ins = 16'h0213;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0;
        #2;
        check("rst.ready", 32'(in_ready), 32'd1);
        check_fr("rst", 1'b0, 16'h0000, 16'hF000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        tick();
        check_fr("post_rst", 1'b0, 16'h0000, 16'hF000, 16'h0000, 16'h0000);

        wb_write(4'hA, 16'h0100);
        wb_write(4'h5, 16'h0042);
        wb_write(4'h1, 16'h0005);
        wb_write(4'h2, 16'h0007);
        wb_write(4'h0, 16'hFFFF);

        // Store field routing; store sets no tracker entry
        offer(16'h0010, 16'h4A15);
        check("store.ready", 32'(in_ready), 32'd1);
        tick();
        check_fr("store", 1'b1, 16'h0010, 16'h4A15, 16'h0042, 16'h0100);
        offer(16'h0012, 16'h0A56);
        check("after_store.ready", 32'(in_ready), 32'd1);
        tick();
        check_fr("alu", 1'b1, 16'h0012, 16'h0A56, 16'h0100, 16'h0042);
        idle(3);

        // Other operand formats
        offer(16'h0020, 16'h7A09);
        tick();
        check_fr("load7", 1'b1, 16'h0020, 16'h7A09, 16'h0100, 16'h0000);
        offer(16'h0022, 16'h6A05);
        tick();
        check_fr("jump", 1'b1, 16'h0022, 16'h6A05, 16'h0042, 16'h0100);
        offer(16'h0024, 16'h5123);
        check("nop.ready", 32'(in_ready), 32'd1);
        tick();
        check_fr("nop", 1'b1, 16'h0024, 16'h5123, 16'h0000, 16'h0000);
        offer(16'h0026, 16'hCA29);
        tick();
        check_fr("memload", 1'b1, 16'h0026, 16'hCA29, 16'h0100, 16'h0000);
        offer(16'h0028, 16'h0900);
        check("memload_dep.ready", 32'(in_ready), 32'd0);
        idle(4);

        // Back-to-back dependency; x2 writes R3 two cycles after issue
        offer(16'h0030, 16'h0213);
        tick();
        check_fr("add1", 1'b1, 16'h0030, 16'h0213, 16'h0007, 16'h0005);
        offer(16'h0032, 16'h0334);
        stalls = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 8 && !done; cyc++) begin
            wb_en = (cyc == 2); wb_reg = 4'h3; wb_data = 16'h000C;
            if (cyc == 1) check_fr("stall_bubble", 1'b0, 16'h0000, 16'hF000, 16'h0000, 16'h0000);
            #1;
            if (in_ready) done = 1'b1;
            else stalls++;
            tick();
        end
        wb_en = 1'b0;
        check("dep.issued", 32'(done), 32'd1);
        check("dep.stalls", 32'(stalls), 32'(EXP_STALLS));
        check_fr("add2", 1'b1, 16'h0032, 16'h0334, 16'h000C, 16'h000C);
        idle(4);

        // Flush while the dependent instruction is stalled
        offer(16'h0040, 16'h0213);
        tick();
        offer(16'h0042, 16'h0334);
        check("flush.pre_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        #1;
        check("flush.ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0;
        check_fr("flush_bubble", 1'b0, 16'h0000, 16'hF000, 16'h0000, 16'h0000);
        offer(16'h0044, 16'h1305);
        check("post_flush.ready", 32'(in_ready), 32'd1);
        tick();
        check_fr("post_flush", 1'b1, 16'h0044, 16'h1305, 16'h000C, 16'h0000);
        idle(4);

        // R0 writer followed by R0 reader
        offer(16'h0050, 16'h0120);
        tick();
        offer(16'h0052, 16'h0005);
        check("r0.ready", 32'(in_ready), 32'd1);
        tick();
        check_fr("r0", 1'b1, 16'h0052, 16'h0005, 16'h0000, 16'h0000);
        idle(4);

        // Same-cycle writeback to R7 while a sub reads it
        offer(16'h0060, 16'h1700);
        wb_en = 1'b1; wb_reg = 4'h7; wb_data = 16'hBEEF;
        #1;
        check("wb_same.ready", 32'(in_ready), 32'd1);
        tick();
        wb_en = 1'b0;
`ifdef WB_BYPASS_EN
        check_fr("bypass", 1'b1, 16'h0060, 16'h1700, 16'hBEEF, 16'h0000);
`else
        check_fr("no_bypass", 1'b1, 16'h0060, 16'h1700, 16'h0000, 16'h0000);
`endif
        idle(4);

        // Reset mid-run with a valid issue slot
        wb_write(4'h5, 16'h1234);
        offer(16'h0070, 16'h0500);
        tick();
        in_valid = 1'b0;
        check_fr("pre_rst", 1'b1, 16'h0070, 16'h0500, 16'h1234, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check_fr("mid_rst", 1'b0, 16'h0000, 16'hF000, 16'h0000, 16'h0000);
        check("mid_rst.ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        offer(16'h0072, 16'h0500);
        tick();
        check_fr("r5_cleared", 1'b1, 16'h0072, 16'h0500, 16'h0000, 16'h0000);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
